// File: rtl/cache_pkg.sv
// Shared definitions for the I-cache refill path.
// Holds AXI4 burst/response/size encodings, the refill FSM state type and
// a helper that sizes the in-line word offset.
package cache_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DONE,
      ST_DRAIN
   } refill_state_e;

   // Bits needed to index a word within a cache line.
   function automatic int unsigned line_off_w(input int unsigned words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/icache_refill_axi.sv
// icache_refill_axi: turns one I-cache line miss into a single AXI4 read
// burst and streams the returned beats into the cache burst-write port.
// One outstanding line at a time.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   miss_valid/ready    miss handshake; miss_addr is the faulting fetch address
//   refill_done/err     one-cycle completion pulse (err: bad rresp or rlast)
//   ar*                 AXI4 read address channel (fixed ID, 4-byte beats)
//   r*                  AXI4 read data channel
//   cache_write_*       registered per-beat cache write (one-cycle latency)
//   crit_word_valid     pulse with the first cache write (feature build only)
//
// Build option: define ICACHE_CRITICAL_WORD_FIRST_EN for critical-word-first
// refill (WRAP burst starting at the missing word).
module icache_refill_axi
   import cache_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 8,
   parameter logic [3:0]  AXI_ID     = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_valid,
   input  logic [31:0] miss_addr,
   output logic        miss_ready,
   output logic        refill_done,
   output logic        refill_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   output logic        crit_word_valid,
`endif
   output logic        cache_write_en,
   output logic [31:0] cache_write_addr,
   output logic [31:0] cache_write_data
);

   localparam int unsigned      OFF_W     = line_off_w(LINE_WORDS);
   localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   refill_state_e    state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             drain_q, drain_d;
   logic             we_q, we_d;
   logic [31:0]      waddr_q, waddr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             crit_q, crit_d;
   logic [OFF_W-1:0] idx;
   logic             last_beat;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         drain_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         crit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         drain_q <= drain_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         crit_q  <= crit_d;
      end
   end

   // Next-state logic; rlast never ends the burst, the beat count does.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (miss_valid) state_d = ST_ADDR;
         ST_ADDR:  if (arready) state_d = ST_DATA;
         ST_DATA:  if (rvalid && last_beat) state_d = ST_DONE;
         ST_DONE:  state_d = drain_q ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: if (rvalid && rlast) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      miss_ready  = (state_q == ST_IDLE);
      arvalid     = (state_q == ST_ADDR);
      rready      = (state_q == ST_DATA) || (state_q == ST_DRAIN);
      refill_done = (state_q == ST_DONE);
      refill_err  = (state_q == ST_DONE) && err_q;
   end

   // Beat counter, error tracking and cache write register
   always_comb begin
      last_beat = (cnt_q == LAST_BEAT);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      // Word index wraps inside the line starting at the critical word.
      idx = cnt_q + addr_q[OFF_W+1:2];
`else
      idx = cnt_q;
`endif
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      drain_d = drain_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      crit_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (miss_valid) begin
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
               addr_d = {miss_addr[31:2], 2'b00};
`else
               addr_d = miss_addr & ~LINE_MASK;
`endif
               cnt_d   = '0;
               err_d   = 1'b0;
               drain_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (rvalid) begin
               we_d    = 1'b1;
               wdata_d = rdata;
               waddr_d = {addr_q[31:OFF_W+2], idx, 2'b00};
               cnt_d   = cnt_q + 1'b1;
               crit_d  = (cnt_q == '0);
               // rlast must appear exactly on the final beat.
               err_d   = err_q | (rresp != AXI_RESP_OKAY) | (rlast != last_beat);
               if (last_beat && !rlast) drain_d = 1'b1;
            end
         end
         ST_DONE: err_d = 1'b0;
         ST_DRAIN: if (rvalid && rlast) drain_d = 1'b0;
         default: ;
      endcase
   end

   assign arid             = AXI_ID;
   assign araddr           = addr_q;
   assign arlen            = 8'(LINE_WORDS - 1);
   assign arsize           = AXI_SIZE_4B;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   assign arburst          = AXI_BURST_WRAP;
   assign crit_word_valid  = crit_q;
`else
   assign arburst          = AXI_BURST_INCR;
   logic  unused_crit;
   assign unused_crit      = crit_q;
`endif
   assign cache_write_en   = we_q;
   assign cache_write_addr = waddr_q;
   assign cache_write_data = wdata_q;

endmodule

// File: tb/tb_icache_refill_axi.sv
// Bench for icache_refill_axi: table of refill scenarios driven through a
// small AXI slave, with expected cache writes queued per beat and popped by
// a monitor. Also a hand-written mid-burst reset sequence.
module tb_icache_refill_axi;

   localparam int unsigned LW = 8;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        miss_ready, refill_done, refill_err;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic        cache_write_en;
   logic [31:0] cache_write_addr, cache_write_data;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   logic        crit_word_valid;
`endif

   always #5 clk = ~clk;

   icache_refill_axi #(.LINE_WORDS(LW), .AXI_ID(4'd5)) dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
      .refill_done(refill_done), .refill_err(refill_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      .crit_word_valid(crit_word_valid),
`endif
      .cache_write_en(cache_write_en), .cache_write_addr(cache_write_addr),
      .cache_write_data(cache_write_data)
   );

   typedef struct {
      string       name;
      logic [31:0] miss_addr;
      int          ar_delay;
      bit          rgap;
      int          err_beat;
      bit          drop_rlast;
      logic [31:0] exp_araddr;
      logic [1:0]  exp_arburst;
      int          exp_writes;
      bit          exp_err;
   } tc_t;

   tc_t         tcs[5];
   logic [63:0] exp_q[$];
   int          checks = 0;
   int          passed = 0;
   int          wr_cnt, done_cnt;
   bit          last_err, done_with_write, mon_en, first_pending;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
   endtask

   // Monitor: every cache write must match the head of the expected queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cache_write_en) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               logic [63:0] e;
               e = exp_q.pop_front();
               check("write_addr", cache_write_addr, e[63:32]);
               check("write_data", cache_write_data, e[31:0]);
            end
            wr_cnt++;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            check("crit_word_valid", 32'(crit_word_valid), 32'(first_pending));
`endif
            first_pending = 1'b0;
         end
         if (refill_done) begin
            done_cnt++;
            last_err        = refill_err;
            done_with_write = cache_write_en;
         end else if (refill_err) begin
            check("err_without_done", 32'(refill_err), 32'd0);
         end
      end
   end

   task automatic clear_stats();
      wr_cnt = 0; done_cnt = 0; last_err = 1'b0;
      done_with_write = 1'b0; first_pending = 1'b1;
   endtask

   // Drive one R beat and hold it until the engine accepts it.
   task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input bit last,
                            input bit expect_write, input logic [31:0] waddr);
      bit ok;
      ok = 1'b0;
      rvalid = 1'b1; rdata = d; rresp = resp; rlast = last;
      if (expect_write) exp_q.push_back({waddr, d});
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         ok = rready;
         @(posedge clk); #1;
         if (ok) break;
      end
      if (!ok) check("r_handshake_timeout", 32'(ok), 32'd1);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
   endtask

   // Issue the miss and complete the AR handshake. Starts just after a posedge.
   task automatic start_miss(input tc_t tc);
      int bad;
      bad = 0;
      miss_valid = 1'b1; miss_addr = tc.miss_addr;
      @(negedge clk);
      check({tc.name, "_miss_ready"}, 32'(miss_ready), 32'd1);
      @(posedge clk); #1;
      miss_valid = 1'b0; miss_addr = ~tc.miss_addr;
      for (int k = 0; k < tc.ar_delay; k++) begin
         @(negedge clk);
         if (!arvalid || araddr !== tc.exp_araddr || miss_ready) bad++;
         @(posedge clk); #1;
      end
      arready = 1'b1;
      @(negedge clk);
      check({tc.name, "_ar_stable"}, 32'(bad), 32'd0);
      check({tc.name, "_arvalid"}, 32'(arvalid), 32'd1);
      check({tc.name, "_araddr"}, araddr, tc.exp_araddr);
      check({tc.name, "_arlen"}, 32'(arlen), 32'(LW - 1));
      check({tc.name, "_arsize"}, 32'(arsize), 32'd2);
      check({tc.name, "_arburst"}, 32'(arburst), 32'(tc.exp_arburst));
      check({tc.name, "_arid"}, 32'(arid), 32'd5);
      @(posedge clk); #1;
      arready = 1'b0;
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] ma, input int b);
      logic [31:0] base;
      int          start;
      base  = ma & ~32'(LW * 4 - 1);
      start = CWF ? int'((ma >> 2) % LW) : 0;
      return base + 32'(((start + b) % LW) * 4);
   endfunction

   task automatic run_refill(input tc_t tc);
      int nbeats;
      clear_stats();
      start_miss(tc);
      nbeats = LW + (tc.drop_rlast ? 1 : 0);
      for (int b = 0; b < nbeats; b++) begin
         if (tc.rgap && (b % 2 == 1)) begin
            @(posedge clk); #1;
         end
         send_beat($urandom, (b == tc.err_beat) ? 2'b10 : 2'b00,
                   tc.drop_rlast ? (b == LW) : (b == LW - 1),
                   b < LW, beat_addr(tc.miss_addr, b));
      end
      for (int k = 0; k < 30 && done_cnt == 0; k++) begin
         @(negedge clk); #1;
      end
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check({tc.name, "_writes"}, 32'(wr_cnt), 32'(tc.exp_writes));
      check({tc.name, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tc.name, "_done_with_write"}, 32'(done_with_write), 32'd1);
      check({tc.name, "_refill_err"}, 32'(last_err), 32'(tc.exp_err));
      check({tc.name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({tc.name, "_idle_after"}, 32'(miss_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_miss_ready"}, 32'(miss_ready), 32'd1);
      check({pfx, "_arvalid"}, 32'(arvalid), 32'd0);
      check({pfx, "_rready"}, 32'(rready), 32'd0);
      check({pfx, "_write_en"}, 32'(cache_write_en), 32'd0);
      check({pfx, "_done"}, 32'(refill_done), 32'd0);
      check({pfx, "_err"}, 32'(refill_err), 32'd0);
      check({pfx, "_araddr"}, araddr, 32'd0);
      check({pfx, "_write_addr"}, cache_write_addr, 32'd0);
      check({pfx, "_write_data"}, cache_write_data, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      tcs[0] = '{"basic", 32'h1000_0014, 0, 1'b0, -1, 1'b0,
                 CWF ? 32'h1000_0014 : 32'h1000_0000, CWF ? 2'b10 : 2'b01, 8, 1'b0};
      tcs[1] = '{"backpressure", 32'h1000_0040, 5, 1'b1, -1, 1'b0,
                 32'h1000_0040, CWF ? 2'b10 : 2'b01, 8, 1'b0};
      tcs[2] = '{"slverr", 32'h3000_0100, 0, 1'b0, 3, 1'b0,
                 32'h3000_0100, CWF ? 2'b10 : 2'b01, 8, 1'b1};
      tcs[3] = '{"crit", 32'h2000_0018, 1, 1'b0, -1, 1'b0,
                 CWF ? 32'h2000_0018 : 32'h2000_0000, CWF ? 2'b10 : 2'b01, 8, 1'b0};
      tcs[4] = '{"no_rlast", 32'h4000_0004, 0, 1'b0, -1, 1'b1,
                 CWF ? 32'h4000_0004 : 32'h4000_0000, CWF ? 2'b10 : 2'b01, 8, 1'b1};

      rst = 1'b0; mon_en = 1'b0;
      miss_valid = 1'b0; miss_addr = '0; arready = 1'b0;
      rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      clear_stats();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1; mon_en = 1'b1;
      @(posedge clk); #1;

      foreach (tcs[i]) run_refill(tcs[i]);

      // Reset after four beats abandons the burst.
      clear_stats();
      start_miss(tcs[0]);
      for (int b = 0; b < 4; b++)
         send_beat($urandom, 2'b00, 1'b0, 1'b1, beat_addr(tcs[0].miss_addr, b));
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midreset_writes_before", 32'(wr_cnt), 32'd4);
      check_reset_outputs("midreset");
      check("midreset_no_done", 32'(done_cnt), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_refill(tcs[1]);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
